// File: rtl/seg7_pkg.sv
// Shared 7-segment types and the active-low pattern table ({g,f,e,d,c,b,a}),
// used by the pair decoder and the display drivers.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam int   NUM_DIGITS = 10;
    localparam seg_t SEG_BLANK  = 7'b1111111;

    localparam seg_t SEG_DIGIT [NUM_DIGITS] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0011000   // 9
    };

    // illegal excludes blank so each position can decide what blank means
    typedef struct packed {
        bcd_t digit;
        logic illegal;
        logic is_blank;
    } digit_dec_t;

endpackage

// File: rtl/seg7_pair_decoder_if.sv
// Valid/ready bus of the pair decoder: pattern pair in, binary value and error status out.
interface seg7_pair_decoder_if
    import seg7_pkg::*;
#(
    parameter int ERR_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    seg_t             d1_seg;
    seg_t             d0_seg;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       out_value;
    logic             out_err;
    logic [ERR_W-1:0] err_count;

    modport slave (
        input  in_valid, d1_seg, d0_seg, out_ready,
        output in_ready, out_valid, out_value, out_err, err_count
    );

    modport master (
        output in_valid, d1_seg, d0_seg, out_ready,
        input  in_ready, out_valid, out_value, out_err, err_count
    );

endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational lookup of one active-low segment pattern to a BCD digit.
// Blank decodes to digit 0 with is_blank set; anything else not in the table is illegal.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  seg_t       i_seg,
    output digit_dec_t o_dec
);

    logic w_match;

    // NOTE: every output gets a default before the loop; otherwise a pattern
    // that matches nothing would leave them unassigned and infer a latch.
    always_comb begin
        w_match        = 1'b0;
        o_dec.digit    = '0;
        o_dec.is_blank = (i_seg == SEG_BLANK);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i_seg == SEG_DIGIT[i]) begin
                w_match     = 1'b1;
                o_dec.digit = bcd_t'(i);
            end
        end
        o_dec.illegal = !w_match && !o_dec.is_blank;
    end

endmodule

// File: rtl/seg7_pair_decoder.sv
// Two-stage valid/ready decoder: tens/ones segment patterns -> binary 0..99 plus error flag.
// Define SEG_BLANK_ZERO_EN to treat a blank tens pattern as 0 (leading-zero suppression).
module seg7_pair_decoder
    import seg7_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    seg7_pair_decoder_if.slave  io_bus
);

    digit_dec_t       w_dec_tens;
    digit_dec_t       w_dec_ones;
    logic             w_tens_err;
    logic             w_ones_err;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_out_fire;
    logic [6:0]       w_tens_x10;
    logic [6:0]       w_sum;

    logic             r_s1_valid;
    bcd_t             r_s1_tens;
    bcd_t             r_s1_ones;
    logic             r_s1_err;
    logic             r_s2_valid;
    logic [6:0]       r_s2_value;
    logic             r_s2_err;
    logic [ERR_W-1:0] r_err_count;

    seg7_digit_decode u_dec_tens (.i_seg(io_bus.d1_seg), .o_dec(w_dec_tens));
    seg7_digit_decode u_dec_ones (.i_seg(io_bus.d0_seg), .o_dec(w_dec_ones));

`ifdef SEG_BLANK_ZERO_EN
    assign w_tens_err = w_dec_tens.illegal;
`else
    assign w_tens_err = w_dec_tens.illegal || w_dec_tens.is_blank;
`endif
    // a blank ones digit never carries a value
    assign w_ones_err = w_dec_ones.illegal || w_dec_ones.is_blank;

    assign w_s2_adv   = !r_s2_valid || io_bus.out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign w_out_fire = r_s2_valid && io_bus.out_ready;

    // NOTE: state registers use non-blocking assignments so every stage samples
    // the pre-edge value of the stage feeding it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= io_bus.in_valid;
        end
    end

    // NOTE: stage-1 payload needs no reset; it is qualified by r_s1_valid,
    // which is reset, so dropping the reset keeps these plain enable flops.
    always_ff @(posedge clk) begin
        if (w_s1_adv && io_bus.in_valid) begin
            r_s1_tens <= w_dec_tens.digit;
            r_s1_ones <= w_dec_ones.digit;
            r_s1_err  <= w_tens_err || w_ones_err;
        end
    end

    assign w_tens_x10 = ({3'b000, r_s1_tens} << 3) + ({3'b000, r_s1_tens} << 1);
    assign w_sum      = w_tens_x10 + {3'b000, r_s1_ones};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_value <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_value <= r_s1_err ? 7'd0 : w_sum;
                r_s2_err   <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_out_fire && r_s2_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    assign io_bus.in_ready  = w_s1_adv;
    assign io_bus.out_valid = r_s2_valid;
    assign io_bus.out_value = r_s2_value;
    assign io_bus.out_err   = r_s2_err;
    assign io_bus.err_count = r_err_count;

endmodule
